// File: rtl/ysyx_23060332_lsu_if.sv
// Bundle of the LSU request, writeback and data-memory signals.
// The LSU binds to the slave modport; its environment (EXU/WBU/memory) binds to master.
interface ysyx_23060332_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              in_is_store;
  logic [2:0]        in_func3;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rdata;
  logic              out_err;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wmask;

  modport slave (
    input  in_valid, in_is_store, in_func3, in_addr, in_wdata, out_ready, mem_rdata,
    output in_ready, out_valid, out_rdata, out_err,
           mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
  );

  modport master (
    output in_valid, in_is_store, in_func3, in_addr, in_wdata, out_ready, mem_rdata,
    input  in_ready, out_valid, out_rdata, out_err,
           mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_23060332_lsu.sv
// Load-store unit: one load/store per transaction, word-aligned memory strobe
// after LATENCY access cycles, lane-extracted/extended result to writeback.
module ysyx_23060332_lsu #(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ysyx_23060332_lsu_if.slave    bus
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        func3_q, func3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              strobe_s;
  logic              accept_s;
  logic              req_err_s;

  // Misalignment or an unsupported funct3 (stores have no unsigned forms).
  function automatic logic req_err(input logic is_store, input logic [2:0] f3,
                                   input logic [1:0] off);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = off[0];
      3'b010:  bad = (off != 2'b00);
      3'b100:  bad = is_store;
      3'b101:  bad = is_store | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [DATA_W-1:0] load_extract(input logic [2:0] f3,
                                                     input logic [DATA_W-1:0] word,
                                                     input logic [1:0] off);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] res;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{(DATA_W-8){sh[7]}}, sh[7:0]};
      3'b001:  res = {{(DATA_W-16){sh[15]}}, sh[15:0]};
      3'b010:  res = sh;
      3'b100:  res = {{(DATA_W-8){1'b0}}, sh[7:0]};
      3'b101:  res = {{(DATA_W-16){1'b0}}, sh[15:0]};
      default: res = {DATA_W{1'b0}};
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3)
      3'b000:  m = 4'b0001 << off;
      3'b001:  m = 4'b0011 << off;
      3'b010:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  assign strobe_s  = (state_q == S_ACCESS) && (cnt_q == CNT_W'(LATENCY - 1));
  assign accept_s  = bus.in_valid && (state_q == S_IDLE);
  assign req_err_s = req_err(bus.in_is_store, bus.in_func3, bus.in_addr[1:0]);

  // Next-state and registered-field update for the request/access/response sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_store_d = is_store_q;
    func3_d    = func3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          is_store_d = bus.in_is_store;
          func3_d    = bus.in_func3;
          addr_d     = bus.in_addr;
          wdata_d    = bus.in_wdata;
          rdata_d    = {DATA_W{1'b0}};
          err_d      = req_err_s;
          cnt_d      = {CNT_W{1'b0}};
          state_d    = req_err_s ? S_RESP : S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (strobe_s) begin
          // Result is captured at the end of the only strobe cycle and held through RESP.
          rdata_d = is_store_q ? {DATA_W{1'b0}}
                               : load_extract(func3_q, bus.mem_rdata, addr_q[1:0]);
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = S_ACCESS;
        end
      end
      S_RESP: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and request registers; reset discards any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      is_store_q <= 1'b0;
      func3_q    <= 3'b000;
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      rdata_q    <= {DATA_W{1'b0}};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_store_q <= is_store_d;
      func3_q    <= func3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Strobes decode straight from state so an async reset kills a pending write at once.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_RESP);
  assign bus.out_rdata = rdata_q;
  assign bus.out_err   = err_q;
  assign bus.mem_ren   = strobe_s & ~is_store_q;
  assign bus.mem_wen   = strobe_s & is_store_q;
  assign bus.mem_raddr = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_waddr = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
  assign bus.mem_wmask = bus.mem_wen ? {4'b0000, store_mask(func3_q, addr_q[1:0])} : 8'h00;

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Randomized self-checking bench: LATENCY=1 and LATENCY=3 instances checked
// against a byte-addressed reference memory and the load/store rules.
module tb_ysyx_23060332_lsu;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_23060332_lsu_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
  ysyx_23060332_lsu_if #(.ADDR_W(32), .DATA_W(32)) if3 ();

  ysyx_23060332_lsu #(.LATENCY(1), .ADDR_W(32), .DATA_W(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));
  ysyx_23060332_lsu #(.LATENCY(3), .ADDR_W(32), .DATA_W(32)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave));

  logic        sel = 1'b0;
  logic        drv_valid = 1'b0, drv_store = 1'b0, drv_oready = 1'b1;
  logic [2:0]  drv_f3 = 3'b000;
  logic [31:0] drv_addr = 32'h0, drv_wdata = 32'h0;

  assign if1.in_valid = drv_valid & ~sel;
  assign if3.in_valid = drv_valid & sel;
  assign if1.in_is_store = drv_store;  assign if3.in_is_store = drv_store;
  assign if1.in_func3 = drv_f3;        assign if3.in_func3 = drv_f3;
  assign if1.in_addr = drv_addr;       assign if3.in_addr = drv_addr;
  assign if1.in_wdata = drv_wdata;     assign if3.in_wdata = drv_wdata;
  assign if1.out_ready = drv_oready;   assign if3.out_ready = drv_oready;

  logic        o_in_ready, o_out_valid, o_err, o_ren, o_wen;
  logic [31:0] o_rdata, o_raddr, o_waddr, o_wdata;
  logic [7:0]  o_wmask;
  assign o_in_ready  = sel ? if3.in_ready  : if1.in_ready;
  assign o_out_valid = sel ? if3.out_valid : if1.out_valid;
  assign o_err       = sel ? if3.out_err   : if1.out_err;
  assign o_rdata     = sel ? if3.out_rdata : if1.out_rdata;
  assign o_ren       = sel ? if3.mem_ren   : if1.mem_ren;
  assign o_wen       = sel ? if3.mem_wen   : if1.mem_wen;
  assign o_raddr     = sel ? if3.mem_raddr : if1.mem_raddr;
  assign o_waddr     = sel ? if3.mem_waddr : if1.mem_waddr;
  assign o_wdata     = sel ? if3.mem_wdata : if1.mem_wdata;
  assign o_wmask     = sel ? if3.mem_wmask : if1.mem_wmask;

  // Word memory seen by the DUTs (256 bytes at BASE) and byte reference memory.
  logic [31:0] mem_w [64];
  logic [7:0]  ref_b [256];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_val = 32'h0;

  assign if1.mem_rdata = mem_w[if1.mem_raddr[7:2]];
  assign if3.mem_rdata = mem_w[if3.mem_raddr[7:2]];

  int          strobes = 0;
  logic [31:0] cap_raddr = 32'h0, cap_waddr = 32'h0, cap_wdata = 32'h0;
  logic [7:0]  cap_mask = 8'h0;

  // Memory write port, preload port and strobe monitor.
  always @(posedge clk) begin
    if (pl_en) mem_w[pl_idx] <= pl_val;
    for (int b = 0; b < 4; b++) begin
      if (if1.mem_wen && if1.mem_wmask[b]) mem_w[if1.mem_waddr[7:2]][8*b +: 8] <= if1.mem_wdata[8*b +: 8];
      if (if3.mem_wen && if3.mem_wmask[b]) mem_w[if3.mem_waddr[7:2]][8*b +: 8] <= if3.mem_wdata[8*b +: 8];
    end
    if (o_ren || o_wen) begin
      strobes   <= strobes + 1;
      cap_raddr <= o_raddr;
      cap_waddr <= o_waddr;
      cap_wdata <= o_wdata;
      cap_mask  <= o_wmask;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic model_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    legal = st ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 1'b1;
    return (a % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int sz, off;
    logic [31:0] v;
    sz = acc_size(f3);
    off = int'(a - BASE);
    v = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_b[off+i]) << (8*i));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int off;
    off = int'((a - BASE) & 32'hFFFF_FFFC);
    return {ref_b[off+3], ref_b[off+2], ref_b[off+1], ref_b[off]};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    int off;
    off = int'((a - BASE) & 32'hFFFF_FFFC);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = a[7:2]; pl_val = v;
    for (int i = 0; i < 4; i++) ref_b[off+i] = 8'((v >> (8*i)) & 32'hFF);
    @(posedge clk); #1 pl_en = 1'b0;
  endtask

  task automatic do_txn(input logic s, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int stall);
    logic        e_err;
    logic [31:0] e_rd, e_mask;
    int          sz, s0, cyc, lat, off;
    e_err = model_err(st, f3, a);
    e_rd  = (st || e_err) ? 32'h0 : model_load(f3, a);
    sz    = acc_size(f3);
    lat   = s ? 3 : 1;
    @(negedge clk);
    sel = s; drv_valid = 1'b1; drv_store = st; drv_f3 = f3; drv_addr = a; drv_wdata = wd;
    drv_oready = (stall == 0);
    chk("in_ready_idle", 32'(o_in_ready), 32'd1);
    s0 = strobes;
    @(posedge clk); #1;
    drv_valid = 1'b0; drv_addr = BASE | ($urandom & 32'hFF); drv_wdata = $urandom; drv_f3 = 3'($urandom);
    @(negedge clk);
    cyc = 1;
    chk("in_ready_busy", 32'(o_in_ready), 32'd0);
    while (!o_out_valid && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), e_err ? 32'd1 : 32'(lat + 1));
    chk("out_err", 32'(o_err), 32'(e_err));
    chk("out_rdata", o_rdata, e_rd);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("held_valid", 32'(o_out_valid), 32'd1);
      chk("held_rdata", o_rdata, e_rd);
      chk("held_in_ready", 32'(o_in_ready), 32'd0);
    end
    drv_oready = 1'b1;
    @(posedge clk);
    chk("strobe_count", 32'(strobes - s0), e_err ? 32'd0 : 32'd1);
    if (!e_err && st) begin
      off = int'(a - BASE);
      e_mask = 32'h0;
      for (int i = 0; i < sz; i++) e_mask = e_mask | (32'd1 << ((a % 4) + i));
      for (int i = 0; i < sz; i++) ref_b[off+i] = 8'((wd >> (8*i)) & 32'hFF);
      chk("waddr", cap_waddr, a & 32'hFFFF_FFFC);
      chk("wdata", cap_wdata, wd << (8 * (a % 4)));
      chk("wmask", 32'(cap_mask), e_mask);
      #1 chk("mem_word", mem_w[a[7:2]], ref_word(a));
    end else if (!e_err) begin
      chk("raddr", cap_raddr, a & 32'hFFFF_FFFC);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(o_in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(o_out_valid), 32'd0);
    chk({tag, "_rdata"}, o_rdata, 32'h0);
    chk({tag, "_err"}, 32'(o_err), 32'd0);
    chk({tag, "_strobes"}, {30'd0, o_ren, o_wen}, 32'd0);
    chk({tag, "_wmask"}, 32'(o_wmask), 32'd0);
    chk({tag, "_waddr"}, o_waddr, 32'h0);
    chk({tag, "_wdata"}, o_wdata, 32'h0);
  endtask

  initial begin
    logic [31:0] a, pre;
    logic [2:0]  f3;
    logic        st;
    #2;
    sel = 1'b0; #1 check_reset_outputs("rst1");
    sel = 1'b1; #1 check_reset_outputs("rst3");
    for (int i = 0; i < 64; i++) set_word(BASE + 32'(4*i), $urandom);
    @(negedge clk) rst_n = 1'b1;

    // Directed cases from the load/store rules.
    set_word(BASE, 32'h8077_6655);
    do_txn(1'b0, 1'b0, 3'b000, BASE + 32'd3, 32'h0, 0);
    set_word(BASE, 32'h8001_1234);
    do_txn(1'b0, 1'b0, 3'b101, BASE + 32'd2, 32'h0, 0);
    do_txn(1'b0, 1'b0, 3'b001, BASE + 32'd2, 32'h0, 0);
    do_txn(1'b0, 1'b1, 3'b000, BASE + 32'd5, 32'h0000_00AB, 0);
    do_txn(1'b0, 1'b1, 3'b001, BASE + 32'd6, 32'h0000_BEEF, 0);
    do_txn(1'b0, 1'b0, 3'b010, BASE + 32'd2, 32'h0, 0);
    do_txn(1'b0, 1'b1, 3'b001, BASE + 32'd1, 32'h1234_5678, 0);
    do_txn(1'b1, 1'b1, 3'b100, BASE + 32'd8, 32'h1234_5678, 0);
    do_txn(1'b1, 1'b0, 3'b011, BASE + 32'd8, 32'h0, 0);
    do_txn(1'b1, 1'b0, 3'b000, BASE + 32'd9, 32'h0, 5);
    do_txn(1'b1, 1'b0, 3'b010, BASE + 32'd12, 32'h0, 0);

    // Reset during the store strobe cycle of the LATENCY=3 instance.
    pre = ref_word(BASE + 32'd16);
    @(negedge clk);
    sel = 1'b1; drv_valid = 1'b1; drv_store = 1'b1; drv_f3 = 3'b010;
    drv_addr = BASE + 32'd16; drv_wdata = ~pre; drv_oready = 1'b1;
    @(posedge clk); #1 drv_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wen_before", 32'(o_wen), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    chk("rst_no_write", mem_w[4], pre);
    @(negedge clk) rst_n = 1'b1;
    do_txn(1'b1, 1'b1, 3'b010, BASE + 32'd16, 32'hCAFE_F00D, 0);

    // Randomized mix on both instances.
    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom);
      f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2) + (st ? 0 : ($urandom_range(0, 1) * 4)))
                                       : 3'($urandom);
      a  = BASE + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      if (f3[1:0] == 2'd3) a = a & 32'hFFFF_FFFC;
      do_txn(1'($urandom), st, f3, a, $urandom, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
